// File: rtl/flash_read_sequencer_if.sv
// Bus bundle for the flash read sequencer: CPU register window, spicore byte port
// and destination memory write port.
interface flash_read_sequencer_if #(
   parameter int MEM_AW = 15
);
   logic              select;
   logic [1:0]        addr;
   logic [3:0]        wr;
   logic [31:0]       data_in;
   logic [31:0]       data_out;
   logic              spi_we;
   logic [7:0]        spi_di;
   logic [7:0]        spi_do;
   logic              spi_ready;
   logic              spi_ss_reset;
   logic [3:0]        mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport master (
      output select, addr, wr, data_in, spi_do, spi_ready,
      input  data_out, spi_we, spi_di, spi_ss_reset, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  select, addr, wr, data_in, spi_do, spi_ready,
      output data_out, spi_we, spi_di, spi_ss_reset, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/flash_read_sequencer.sv
// Autonomous SPI flash READ (0x03) engine: drives spicore byte by byte and
// streams received bytes into a byte-lane memory write port.
module flash_read_sequencer #(
   parameter int LEN_WIDTH = 16,
   parameter int MEM_AW    = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   flash_read_sequencer_if.slave bus,
   output logic                  interrupt,
   output logic                  busy
);
   localparam int DW = MEM_AW + 2;

   typedef enum logic [2:0] {S_IDLE, S_CSRST, S_CMD, S_A2, S_A1, S_A0, S_DATA, S_FIN} state_t;
   typedef enum logic [1:0] {P_ISSUE, P_WAIT_LOW, P_WAIT_HIGH} phase_t;

   state_t               state_q, state_d;
   phase_t               phase_q, phase_d;
   logic [23:0]          flash_addr_q, flash_addr_d;
   logic [DW-1:0]        dest_addr_q, dest_addr_d;
   logic [LEN_WIDTH-1:0] length_q, length_d;
   logic [DW-1:0]        dest_cnt_q, dest_cnt_d;
   logic [LEN_WIDTH-1:0] rem_q, rem_d;
   logic                 int_en_q, int_en_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;
   logic                 spi_we_q, spi_we_d;
   logic [7:0]           spi_di_q, spi_di_d;
   logic                 spi_ss_reset_q, spi_ss_reset_d;
   logic [3:0]           mem_we_q, mem_we_d;
   logic [MEM_AW-1:0]    mem_addr_q, mem_addr_d;
   logic [31:0]          mem_wdata_q, mem_wdata_d;

   logic                 cpu_wr, ctrl_wr, start, abort, set_done;
   logic [7:0]           tx_byte;
   logic [31:0]          rd_data;

   assign cpu_wr  = bus.select && (bus.wr != 4'b0000);
   assign ctrl_wr = cpu_wr && (bus.addr == 2'd3);
   assign start   = ctrl_wr && bus.data_in[0] && !busy_q;
   // FIN is already on its way out, so an abort there has nothing left to cut short
   assign abort   = ctrl_wr && bus.data_in[3] && (state_q != S_IDLE) && (state_q != S_FIN);

   always_comb begin
      case (state_q)
         S_CMD:   tx_byte = 8'h03;
         S_A2:    tx_byte = flash_addr_q[23:16];
         S_A1:    tx_byte = flash_addr_q[15:8];
         S_A0:    tx_byte = flash_addr_q[7:0];
         default: tx_byte = 8'h00;
      endcase
   end

   always_comb begin
      case (bus.addr)
         2'd0:    rd_data = {8'h00, flash_addr_q};
         2'd1:    rd_data = 32'(dest_addr_q);
         2'd2:    rd_data = 32'(length_q);
         default: rd_data = {29'b0, int_en_q, done_q, busy_q};
      endcase
   end

   always_comb begin
      state_d        = state_q;
      phase_d        = phase_q;
      flash_addr_d   = flash_addr_q;
      dest_addr_d    = dest_addr_q;
      length_d       = length_q;
      dest_cnt_d     = dest_cnt_q;
      rem_d          = rem_q;
      int_en_d       = int_en_q;
      done_d         = done_q;
      spi_we_d       = 1'b0;
      spi_di_d       = spi_di_q;
      spi_ss_reset_d = 1'b0;
      mem_we_d       = 4'b0000;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      set_done       = 1'b0;

      if (cpu_wr && !busy_q) begin
         case (bus.addr)
            2'd0:    flash_addr_d = bus.data_in[23:0];
            2'd1:    dest_addr_d  = bus.data_in[DW-1:0];
            2'd2:    length_d     = bus.data_in[LEN_WIDTH-1:0];
            default: ;
         endcase
      end
      if (ctrl_wr) begin
         int_en_d = bus.data_in[2];
         if (bus.data_in[1]) done_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (length_q == '0) begin
                  set_done = 1'b1;
               end else begin
                  state_d        = S_CSRST;
                  spi_ss_reset_d = 1'b1;
                  dest_cnt_d     = dest_addr_q;
                  rem_d          = length_q;
               end
            end
         end
         S_CSRST: begin
            state_d = S_CMD;
            phase_d = P_ISSUE;
         end
         S_FIN: state_d = S_IDLE;
         default: begin
            // every byte: issue when spicore is idle, see it go busy, then wait for completion
            case (phase_q)
               P_ISSUE: begin
                  if (bus.spi_ready) begin
                     spi_we_d = 1'b1;
                     spi_di_d = tx_byte;
                     phase_d  = P_WAIT_LOW;
                  end
               end
               P_WAIT_LOW: begin
                  if (!bus.spi_ready) phase_d = P_WAIT_HIGH;
               end
               default: begin
                  if (bus.spi_ready) begin
                     phase_d = P_ISSUE;
                     case (state_q)
                        S_CMD:   state_d = S_A2;
                        S_A2:    state_d = S_A1;
                        S_A1:    state_d = S_A0;
                        S_A0:    state_d = S_DATA;
                        default: begin
                           mem_we_d    = 4'b0001 << dest_cnt_q[1:0];
                           mem_addr_d  = dest_cnt_q[DW-1:2];
                           mem_wdata_d = {4{bus.spi_do}};
                           dest_cnt_d  = dest_cnt_q + DW'(1);
                           if (rem_q != '0) rem_d = rem_q - LEN_WIDTH'(1);
                           if (rem_q <= LEN_WIDTH'(1)) begin
                              state_d        = S_FIN;
                              spi_ss_reset_d = 1'b1;
                              set_done       = 1'b1;
                           end
                        end
                     endcase
                  end
               end
            endcase
         end
      endcase

      if (abort) begin
         state_d        = S_FIN;
         spi_ss_reset_d = 1'b1;
         spi_we_d       = 1'b0;
         mem_we_d       = 4'b0000;
         set_done       = 1'b0;
      end
      // completion beats a same-cycle clear-done write
      if (set_done) done_d = 1'b1;
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         phase_q        <= P_ISSUE;
         flash_addr_q   <= '0;
         dest_addr_q    <= '0;
         length_q       <= '0;
         dest_cnt_q     <= '0;
         rem_q          <= '0;
         int_en_q       <= 1'b0;
         done_q         <= 1'b0;
         busy_q         <= 1'b0;
         spi_we_q       <= 1'b0;
         spi_di_q       <= 8'h00;
         spi_ss_reset_q <= 1'b0;
         mem_we_q       <= 4'b0000;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
      end else begin
         state_q        <= state_d;
         phase_q        <= phase_d;
         flash_addr_q   <= flash_addr_d;
         dest_addr_q    <= dest_addr_d;
         length_q       <= length_d;
         dest_cnt_q     <= dest_cnt_d;
         rem_q          <= rem_d;
         int_en_q       <= int_en_d;
         done_q         <= done_d;
         busy_q         <= busy_d;
         spi_we_q       <= spi_we_d;
         spi_di_q       <= spi_di_d;
         spi_ss_reset_q <= spi_ss_reset_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
      end
   end

   assign bus.data_out     = rd_data;
   assign bus.spi_we       = spi_we_q;
   assign bus.spi_di       = spi_di_q;
   assign bus.spi_ss_reset = spi_ss_reset_q;
   assign bus.mem_we       = mem_we_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_wdata    = mem_wdata_q;
   assign interrupt        = done_q & int_en_q;
   assign busy             = busy_q;
endmodule

// File: tb/tb_flash_read_sequencer.sv
// Scoreboard bench for flash_read_sequencer with a behavioural spicore model.
module tb_flash_read_sequencer;
   localparam int MEM_AW    = 16;
   localparam int LEN_WIDTH = 16;

   logic clk = 1'b0;
   logic reset;
   logic interrupt, busy;
   always #5 clk = ~clk;

   flash_read_sequencer_if #(.MEM_AW(MEM_AW)) bus();

   flash_read_sequencer #(.LEN_WIDTH(LEN_WIDTH), .MEM_AW(MEM_AW)) dut (
      .clk(clk), .reset(reset), .bus(bus), .interrupt(interrupt), .busy(busy)
   );

   typedef struct {
      logic [3:0]  we;
      logic [31:0] addr;
      logic [7:0]  d;
   } wr_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  exp_mosi[$];
   wr_t         exp_wr[$];
   int          we_cnt = 0, ssr_cnt = 0, mw_cnt = 0;
   int          k = 0, model_cnt = 0;
   logic [7:0]  resp_base = 8'hA0;
   logic [7:0]  resp_hold = 8'h00;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // spicore model plus scoreboard consumer for MOSI bytes and memory writes
   always @(negedge clk) begin
      wr_t e;
      if (reset) begin
         bus.spi_ready = 1'b1;
         bus.spi_do    = 8'h00;
         model_cnt     = 0;
         k             = 0;
      end else begin
         if (bus.spi_ss_reset) begin
            ssr_cnt++;
            k = 0;
         end
         if (bus.spi_we) begin
            we_cnt++;
            if (exp_mosi.size() == 0) chk("mosi_unexpected", 32'(bus.spi_di), 32'hFFFF_FFFF);
            else chk("mosi", 32'(bus.spi_di), 32'(exp_mosi.pop_front()));
            resp_hold     = (k < 4) ? 8'hEE : resp_base + 8'(k - 4);
            k++;
            bus.spi_ready = 1'b0;
            model_cnt     = 4;
         end else if (model_cnt > 0) begin
            model_cnt--;
            if (model_cnt == 0) begin
               bus.spi_ready = 1'b1;
               bus.spi_do    = resp_hold;
            end
         end
         if (bus.mem_we != 4'b0000) begin
            mw_cnt++;
            if (exp_wr.size() == 0) chk("wr_unexpected", 32'(bus.mem_we), 32'h0);
            else begin
               e = exp_wr.pop_front();
               chk("wr_lane", 32'(bus.mem_we), 32'(e.we));
               chk("wr_addr", 32'(bus.mem_addr), e.addr);
               chk("wr_data", bus.mem_wdata, {4{e.d}});
            end
         end
      end
   end

   task automatic cpu_wr(input logic [1:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      bus.select = 1'b1; bus.addr = a; bus.wr = 4'hF; bus.data_in = d;
      @(posedge clk); #1;
      bus.select = 1'b0; bus.wr = 4'h0;
   endtask

   task automatic cpu_rd(input logic [1:0] a, output logic [31:0] d);
      bus.addr = a;
      #1;
      d = bus.data_out;
   endtask

   task automatic push_xfer(input logic [23:0] fa, input logic [31:0] dest,
                            input int n_zero, input int n_wr);
      wr_t e;
      logic [31:0] dd;
      exp_mosi.push_back(8'h03);
      exp_mosi.push_back(fa[23:16]);
      exp_mosi.push_back(fa[15:8]);
      exp_mosi.push_back(fa[7:0]);
      for (int i = 0; i < n_zero; i++) exp_mosi.push_back(8'h00);
      for (int i = 0; i < n_wr; i++) begin
         dd     = (dest + 32'(i)) & 32'h3FFFF;
         e.we   = 4'b0001 << dd[1:0];
         e.addr = dd >> 2;
         e.d    = resp_base + 8'(i);
         exp_wr.push_back(e);
      end
   endtask

   task automatic run_xfer(input logic [23:0] fa, input logic [31:0] dest, input int len);
      cpu_wr(2'd0, 32'(fa));
      cpu_wr(2'd1, dest);
      cpu_wr(2'd2, 32'(len));
      push_xfer(fa, dest, len, len);
      cpu_wr(2'd3, 32'h5);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int i = 0; i < budget && busy; i++) @(negedge clk);
      chk(tag, 32'(busy), 32'h0);
   endtask

   task automatic chk_drained(input string tag);
      chk({tag, "_mosi_left"}, 32'(exp_mosi.size()), 32'h0);
      chk({tag, "_wr_left"}, 32'(exp_wr.size()), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int b_we, b_ss, b_mw, i;
      reset = 1'b1;
      bus.select = 1'b0; bus.addr = 2'd0; bus.wr = 4'h0; bus.data_in = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_irq", 32'(interrupt), 32'h0);
      chk("rst_spi_we", 32'(bus.spi_we), 32'h0);
      chk("rst_ss", 32'(bus.spi_ss_reset), 32'h0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
      chk("rst_spi_di", 32'(bus.spi_di), 32'h0);
      for (int a = 0; a < 4; a++) begin
         cpu_rd(a[1:0], rd);
         chk($sformatf("rst_reg%0d", a), rd, 32'h0);
      end
      reset = 1'b0;
      repeat (2) @(posedge clk);

      // basic 4-byte read with interrupt enabled
      b_we = we_cnt; b_ss = ssr_cnt; b_mw = mw_cnt;
      resp_base = 8'hA0;
      run_xfer(24'h012345, 32'h20000, 4);
      chk("t1_busy_n1", 32'(busy), 32'h1);
      chk("t1_ss_n1", 32'(bus.spi_ss_reset), 32'h1);
      chk("t1_we_n1", 32'(bus.spi_we), 32'h0);
      bus.addr = 2'd3;
      @(negedge clk);
      i = 0;
      do begin
         @(negedge clk);
         i++;
      end while (!bus.spi_ss_reset && i < 1000);
      chk("t1_fin_ss", 32'(bus.spi_ss_reset), 32'h1);
      chk("t1_fin_done", 32'(bus.data_out[1]), 32'h1);
      chk("t1_fin_busy", 32'(busy), 32'h1);
      @(negedge clk);
      chk("t1_post_fin_busy", 32'(busy), 32'h0);
      chk("t1_post_fin_ss", 32'(bus.spi_ss_reset), 32'h0);
      wait_idle("t1_idle", 1000);
      cpu_rd(2'd3, rd); chk("t1_ctrl", rd, 32'h6);
      chk("t1_irq", 32'(interrupt), 32'h1);
      chk("t1_nwe", 32'(we_cnt - b_we), 32'd8);
      chk("t1_nss", 32'(ssr_cnt - b_ss), 32'd2);
      chk("t1_nmw", 32'(mw_cnt - b_mw), 32'd4);
      cpu_rd(2'd0, rd); chk("t1_rd_fa", rd, 32'h012345);
      cpu_rd(2'd1, rd); chk("t1_rd_dest", rd, 32'h20000);
      cpu_rd(2'd2, rd); chk("t1_rd_len", rd, 32'h4);
      chk_drained("t1");

      // unaligned destination crossing a word boundary
      cpu_wr(2'd3, 32'h6);
      chk("t2_irq_clear", 32'(interrupt), 32'h0);
      b_mw = mw_cnt;
      resp_base = 8'h50;
      run_xfer(24'h000100, 32'h3, 3);
      wait_idle("t2_idle", 1000);
      chk("t2_nmw", 32'(mw_cnt - b_mw), 32'd3);
      chk("t2_irq", 32'(interrupt), 32'h1);
      chk_drained("t2");

      // zero length: immediate done, no SPI traffic
      cpu_wr(2'd3, 32'h2);
      cpu_wr(2'd2, 32'h0);
      b_we = we_cnt; b_ss = ssr_cnt;
      cpu_wr(2'd3, 32'h1);
      cpu_rd(2'd3, rd); chk("t3_ctrl", rd, 32'h2);
      repeat (10) @(negedge clk);
      chk("t3_nwe", 32'(we_cnt - b_we), 32'd0);
      chk("t3_nss", 32'(ssr_cnt - b_ss), 32'd0);

      // abort while the third data byte is in flight
      cpu_wr(2'd3, 32'h2);
      resp_base = 8'h70;
      cpu_wr(2'd0, 32'hABCDEF);
      cpu_wr(2'd1, 32'h40);
      cpu_wr(2'd2, 32'd8);
      push_xfer(24'hABCDEF, 32'h40, 3, 2);
      b_we = we_cnt; b_ss = ssr_cnt; b_mw = mw_cnt;
      cpu_wr(2'd3, 32'h1);
      for (int j = 0; j < 1000 && we_cnt < b_we + 7; j++) @(negedge clk);
      chk("t4_reach_byte7", 32'(we_cnt - b_we), 32'd7);
      cpu_wr(2'd3, 32'h8);
      chk("t4_abort_ss", 32'(bus.spi_ss_reset), 32'h1);
      wait_idle("t4_idle", 20);
      cpu_rd(2'd3, rd); chk("t4_ctrl", rd, 32'h0);
      chk("t4_nmw", 32'(mw_cnt - b_mw), 32'd2);
      chk("t4_nss", 32'(ssr_cnt - b_ss), 32'd2);
      repeat (10) @(negedge clk);
      chk_drained("t4");

      // register writes and restart are ignored while busy
      resp_base = 8'h30;
      b_we = we_cnt; b_ss = ssr_cnt; b_mw = mw_cnt;
      run_xfer(24'h000010, 32'h100, 4);
      cpu_wr(2'd2, 32'd9);
      cpu_wr(2'd3, 32'h5);
      cpu_rd(2'd2, rd); chk("t5_len_kept", rd, 32'h4);
      chk("t5_still_busy", 32'(busy), 32'h1);
      wait_idle("t5_idle", 1000);
      chk("t5_nwe", 32'(we_cnt - b_we), 32'd8);
      chk("t5_nss", 32'(ssr_cnt - b_ss), 32'd2);
      chk("t5_nmw", 32'(mw_cnt - b_mw), 32'd4);
      chk_drained("t5");

      // asynchronous reset in the middle of the data phase
      cpu_wr(2'd3, 32'h2);
      resp_base = 8'h90;
      b_mw = mw_cnt;
      run_xfer(24'h112233, 32'h200, 6);
      for (int j = 0; j < 1000 && mw_cnt < b_mw + 1; j++) @(negedge clk);
      chk("t6_reach_data", 32'(mw_cnt - b_mw), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("t6_busy", 32'(busy), 32'h0);
      chk("t6_spi_we", 32'(bus.spi_we), 32'h0);
      chk("t6_ss", 32'(bus.spi_ss_reset), 32'h0);
      chk("t6_mem_we", 32'(bus.mem_we), 32'h0);
      chk("t6_spi_di", 32'(bus.spi_di), 32'h0);
      chk("t6_irq", 32'(interrupt), 32'h0);
      cpu_rd(2'd2, rd); chk("t6_len", rd, 32'h0);
      exp_mosi.delete();
      exp_wr.delete();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);

      // fresh transfer after reset, destination wrapping past the top
      resp_base = 8'h10;
      b_we = we_cnt; b_ss = ssr_cnt; b_mw = mw_cnt;
      run_xfer(24'h000400, 32'h3FFFF, 2);
      wait_idle("t7_idle", 1000);
      cpu_rd(2'd3, rd); chk("t7_ctrl", rd, 32'h6);
      chk("t7_nwe", 32'(we_cnt - b_we), 32'd6);
      chk("t7_nss", 32'(ssr_cnt - b_ss), 32'd2);
      chk("t7_nmw", 32'(mw_cnt - b_mw), 32'd2);
      chk_drained("t7");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
